dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder for the 5-stage MIPS pipeline; it sits at the far end of the MEM-stage load/store interface.
- Accepts one word read/write request at a time, models a configurable access latency, returns read data with a one-cycle valid pulse.
- Drives a stall line to the hazard unit so IF/ID/EX/MEM freeze while an access is outstanding.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, word width (fixed at 32 in this design).
- DEPTH_WORDS, 256, number of storage words.
- LATENCY, 2, cycles from request acceptance to response; legal range 1..15.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  1  MEM stage holds a load/store (MemRead|MemWrite).
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address (ALU result).
- req_wdata  in  DATA_W  store data.
- req_ready  out  1  request accepted this cycle when high with req_valid.
- resp_valid  out  1  one-cycle completion pulse (loads and stores).
- resp_rdata  out  DATA_W  load data, valid with resp_valid; 0 otherwise.
- resp_err  out  1  with resp_valid: misaligned or out-of-range address.
- stall  out  1  to hazard unit: freeze pipeline.

Behaviour:
- Reset:
  - Applied while reset==0 at a clock edge.
  - FSM goes to IDLE, counter = 0.
  - Outputs: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, stall=0.
  - Storage array is not cleared.
- FSM states:
  - IDLE: req_ready=1. req_valid=1 accepts the request: latch write/addr/wdata, load cnt=LATENCY-1, go to WAIT.
  - WAIT: req_ready=0. Decrement cnt; at cnt==0 go to RESP.
  - RESP: req_ready=0, resp_valid=1 for exactly one cycle, then IDLE.
- Timing:
  - Request accepted in cycle T; resp_valid is high in cycle T+LATENCY+... counted as: WAIT occupies LATENCY cycles, RESP follows.
  - Throughput: one request per LATENCY+2 cycles.
- stall = (IDLE & req_valid) | WAIT. stall is low in RESP, so the pipeline advances on the RESP edge.
  - The request still visible in RESP is the one already served; it is never re-accepted because ready=0 in RESP.
- Address check uses the latched address:
  - Misaligned: addr[1:0] != 0.
  - Out of range: addr[ADDR_W-1:2] >= DEPTH_WORDS.
  - Either sets resp_err=1 in RESP. Read data is forced to 0, and a store is dropped.
- Stores:
  - Array written on the clock edge ending the RESP cycle, only if no error.
  - A store aborted by reset before that edge leaves the array unchanged.
- Loads:
  - resp_rdata is the array word read in RESP, so a load after a store to the same address returns the new value.
  - resp_rdata = 0 whenever resp_valid = 0.
- req_wdata/req_addr changes after acceptance are ignored.
- Reset mid-operation: state discarded, next cycle is IDLE, no resp_valid pulse for the aborted request.

Optional Feature:
- Macro: DMEM_BYTE_STROBE_EN.
- Defined:
  - Adds input req_be[3:0]; a store writes only the bytes whose strobe bit is set.
  - Alignment check uses req_be: the access must not cross a word boundary.
  - req_be==0 on a store is a no-op completing normally.
- Undefined:
  - Port absent; all stores write the full word.

Decomposition:
- Package dmem_pkg holds:
  - FSM state enum (IDLE, WAIT, RESP).
  - Error-code constants.
  - WORD_BYTES=4.
- One sub-module, dmem_array: synchronous-write word array with optional byte enables and a combinational read port.
  - FSM, counter and checks stay in dmem_responder.

Test Plan:
- Reset then idle, reset held 0 for 3 cycles: req_ready=1, stall=0, resp_valid=0, resp_rdata=0.
- Store then load, LATENCY=2:
  - Store 0x0000_0010 <- 0xDEADBEEF: resp_valid pulses once, resp_err=0.
  - Load 0x10: resp_rdata=0xDEADBEEF.
  - stall high for 3 cycles each access.
- Misaligned store to 0x13 with data 0x1234: resp_err=1. A following load of 0x10 returns the prior value unchanged.
- Out-of-range load at addr 0x400 (word 256, DEPTH_WORDS=256): resp_err=1, resp_rdata=0.
- Back-to-back loads with req_valid held high across RESP: exactly one response per request, second accepted only the cycle after RESP.
- Reset asserted during WAIT of a store 0x20 <- 0x5: no resp_valid pulse, FSM IDLE next cycle, a later load of 0x20 returns the old value.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the MEM-stage data-memory responder.
//   dmem_state_e  : responder FSM states (idle / wait out latency / respond)
//   ERR_*         : 2-bit error codes derived from the latched request address
//   WORD_BYTES    : bytes per storage word
//   WORD_OFF_W    : width of the byte offset inside a word
package dmem_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } dmem_state_e;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_MISALIGN = 2'd1;
    localparam logic [1:0] ERR_RANGE    = 2'd2;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned WORD_OFF_W = $clog2(WORD_BYTES);

endpackage

// File: rtl/dmem_array.sv
// dmem_array: word-organised storage with a synchronous, byte-enabled write port and a
// combinational read port. Contents are not affected by reset.
// Ports:
//   clock  in   write clock, rising edge
//   we     in   write enable
//   be     in   per-byte write enables (bit b covers wdata[8b+7:8b])
//   waddr  in   word index to write
//   wdata  in   write data
//   raddr  in   word index to read
//   rdata  out  combinational read data
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned IDX_W       = 8
) (
    input  logic                  clock,
    input  logic                  we,
    input  logic [WORD_BYTES-1:0] be,
    input  logic [IDX_W-1:0]      waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [IDX_W-1:0]      raddr,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clock) begin
        if (we) begin
            for (int b = 0; b < WORD_BYTES; b++) begin
                if (be[b]) begin
                    mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder at the far end of the MEM-stage load/store
// interface. Accepts one word request at a time, waits LATENCY cycles, then gives a
// one-cycle response. Stall holds IF/ID/EX/MEM while an access is outstanding.
// Optional feature: define DMEM_BYTE_STROBE_EN to add req_be (byte strobes for stores;
// the strobed bytes, placed at the address offset, must stay inside one word).
// Ports:
//   clock       in   rising-edge clock
//   reset       in   synchronous active-low reset
//   req_valid   in   MEM stage holds a load or store
//   req_write   in   1 = store, 0 = load
//   req_addr    in   byte address
//   req_wdata   in   store data
//   req_be      in   byte strobes (DMEM_BYTE_STROBE_EN builds only)
//   req_ready   out  request accepted when high together with req_valid
//   resp_valid  out  one-cycle completion pulse
//   resp_rdata  out  load data while resp_valid, else 0
//   resp_err    out  misaligned / out-of-range, valid with resp_valid
//   stall       out  freeze the pipeline
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
`ifdef DMEM_BYTE_STROBE_EN
    input  logic [WORD_BYTES-1:0] req_be,
`endif
    output logic                  req_ready,
    output logic                  resp_valid,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  resp_err,
    output logic                  stall
);

    localparam int unsigned IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned WORD_W   = ADDR_W - WORD_OFF_W;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    dmem_state_e         state_q;
    logic [3:0]          cnt_q;
    logic                write_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
`ifdef DMEM_BYTE_STROBE_EN
    logic [WORD_BYTES-1:0] be_q;
`endif

    // Request capture and latency counter. WAIT lasts LATENCY cycles because the
    // counter starts at LATENCY-1 and RESP is entered on the cycle it reads zero.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef DMEM_BYTE_STROBE_EN
            be_q    <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        write_q <= req_write;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
`ifdef DMEM_BYTE_STROBE_EN
                        be_q    <= req_be;
`endif
                        cnt_q   <= CNT_INIT;
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= StResp;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Address checks on the latched request.
    logic [WORD_OFF_W-1:0] off;
    logic [WORD_W-1:0]     word_idx;
    logic                  misalign;
    logic                  out_of_range;
    logic [1:0]            err_code;
    logic [WORD_BYTES-1:0] wr_lanes;
    logic [DATA_W-1:0]     wr_data;

    assign off      = addr_q[WORD_OFF_W-1:0];
    assign word_idx = addr_q[ADDR_W-1:WORD_OFF_W];

`ifdef DMEM_BYTE_STROBE_EN
    // Strobes are placed at the byte offset; any lane pushed past the word is a crossing.
    logic [2*WORD_BYTES-1:0] lanes;
    assign lanes    = {{WORD_BYTES{1'b0}}, be_q} << off;
    assign misalign = lanes[2*WORD_BYTES-1:WORD_BYTES] != '0;
    assign wr_lanes = lanes[WORD_BYTES-1:0];
    assign wr_data  = wdata_q << {off, 3'b000};
`else
    assign misalign = off != '0;
    assign wr_lanes = '1;
    assign wr_data  = wdata_q;
`endif

    assign out_of_range = word_idx >= WORD_W'(DEPTH_WORDS);

    always_comb begin
        err_code = ERR_NONE;
        if (misalign) begin
            err_code = ERR_MISALIGN;
        end else if (out_of_range) begin
            err_code = ERR_RANGE;
        end
    end

    logic              in_resp;
    logic              has_err;
    logic              array_we;
    logic [DATA_W-1:0] array_rdata;

    assign in_resp  = state_q == StResp;
    assign has_err  = err_code != ERR_NONE;
    // Gating with reset means a reset on the RESP edge aborts the store.
    assign array_we = in_resp & write_q & ~has_err & reset;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .DATA_W      (DATA_W),
        .IDX_W       (IDX_W)
    ) u_array (
        .clock (clock),
        .we    (array_we),
        .be    (wr_lanes),
        .waddr (addr_q[IDX_W+WORD_OFF_W-1:WORD_OFF_W]),
        .wdata (wr_data),
        .raddr (addr_q[IDX_W+WORD_OFF_W-1:WORD_OFF_W]),
        .rdata (array_rdata)
    );

    assign req_ready  = state_q == StIdle;
    assign stall      = ((state_q == StIdle) & req_valid) | (state_q == StWait);
    assign resp_valid = in_resp;
    assign resp_err   = in_resp & has_err;
    assign resp_rdata = (in_resp & ~write_q & ~has_err) ? array_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (default build, LATENCY=2, DEPTH_WORDS=256).
module tb_dmem_responder;

    localparam int LAT = 2;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        stall;

    int n_vec = 0;
    int n_bad = 0;

    dmem_responder #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .DEPTH_WORDS (256),
        .LATENCY     (LAT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .stall      (stall)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // One access from IDLE, sampled at falling edges. Address/data are scrambled after
    // acceptance; req_valid drops once the response is seen.
    task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rd, output logic er,
                          output int stalls, output int resps, output int leaks);
        stalls = 0;
        resps  = 0;
        leaks  = 0;
        rd     = 32'hFFFF_FFFF;
        er     = 1'b0;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        for (int c = 0; c < LAT + 4; c++) begin
            #1;
            if (stall) stalls++;
            if (resp_valid) begin
                resps++;
                rd = resp_rdata;
                er = resp_err;
                req_valid = 1'b0;
            end else if (resp_rdata != 32'd0) begin
                leaks++;
            end
            if (c == 1) begin
                req_addr  = addr ^ 32'h4;
                req_wdata = ~wdata;
            end
            @(negedge clock);
        end
        req_valid = 1'b0;
    endtask

    logic [31:0] rd;
    logic        er;
    int          stalls, resps, leaks;
    int          acc_cyc[$];
    int          rsp_cyc[$];
    int          extra;

    initial begin
        vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,          1'b0};
        vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF,  1'b0};
        vecs[2]  = '{1'b1, 32'h0000_0013, 32'h0000_1234, 32'h0,          1'b1};
        vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF,  1'b0};
        vecs[4]  = '{1'b0, 32'h0000_0400, 32'h0,         32'h0,          1'b1};
        vecs[5]  = '{1'b1, 32'h0000_0020, 32'hCAFE_0000, 32'h0,          1'b0};
        vecs[6]  = '{1'b0, 32'h0000_0020, 32'h0,         32'hCAFE_0000,  1'b0};
        vecs[7]  = '{1'b1, 32'h0000_03FC, 32'h1122_3344, 32'h0,          1'b0};
        vecs[8]  = '{1'b0, 32'h0000_03FC, 32'h0,         32'h1122_3344,  1'b0};
        vecs[9]  = '{1'b0, 32'h0000_0012, 32'h0,         32'h0,          1'b1};
        vecs[10] = '{1'b1, 32'h0000_0000, 32'hA5A5_5A5A, 32'h0,          1'b0};
        vecs[11] = '{1'b0, 32'h0000_0000, 32'h0,         32'hA5A5_5A5A,  1'b0};

        reset     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        repeat (3) @(negedge clock);
        chk("reset req_ready", {31'd0, req_ready}, 32'd1);
        chk("reset stall", {31'd0, stall}, 32'd0);
        chk("reset resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("reset resp_rdata", resp_rdata, 32'd0);
        reset = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 12; i++) begin
            access(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, er, stalls, resps, leaks);
            chk($sformatf("v%0d resp count", i), resps, 32'd1);
            chk($sformatf("v%0d stall cycles", i), stalls, LAT + 1);
            chk($sformatf("v%0d resp_err", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
            chk($sformatf("v%0d rdata idle leak", i), leaks, 32'd0);
            if (!vecs[i].wr) begin
                chk($sformatf("v%0d resp_rdata", i), rd, vecs[i].exp_rd);
            end
        end

        // Back-to-back loads with req_valid held high through RESP.
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h10;
        for (int c = 0; c < 2 * (LAT + 2); c++) begin
            #1;
            if (req_ready && req_valid) acc_cyc.push_back(c);
            if (resp_valid) begin
                rsp_cyc.push_back(c);
                chk($sformatf("b2b rdata c%0d", c), resp_rdata, 32'hDEAD_BEEF);
                if (rsp_cyc.size() == 2) req_valid = 1'b0;
            end
            @(negedge clock);
        end
        req_valid = 1'b0;
        chk("b2b accept count", acc_cyc.size(), 32'd2);
        chk("b2b resp count", rsp_cyc.size(), 32'd2);
        if (acc_cyc.size() == 2 && rsp_cyc.size() == 2) begin
            chk("b2b first resp cycle", rsp_cyc[0], LAT + 1);
            chk("b2b second accept cycle", acc_cyc[1], rsp_cyc[0] + 1);
        end
        #1;
        chk("b2b idle after", {31'd0, req_ready}, 32'd1);
        @(negedge clock);

        // Reset during WAIT of a store: no response, no write.
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'h5;
        @(negedge clock);
        chk("abort in wait stall", {31'd0, stall}, 32'd1);
        reset     = 1'b0;
        req_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("abort idle ready", {31'd0, req_ready}, 32'd1);
        chk("abort idle stall", {31'd0, stall}, 32'd0);
        extra = 0;
        for (int c = 0; c < LAT + 3; c++) begin
            if (resp_valid) extra++;
            @(negedge clock);
            #1;
        end
        chk("abort no resp pulse", extra, 32'd0);
        @(negedge clock);
        access(1'b0, 32'h20, 32'h0, rd, er, stalls, resps, leaks);
        chk("abort reload count", resps, 32'd1);
        chk("abort reload rdata", rd, 32'hCAFE_0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
